// File: rtl/comparator_iterative.sv
`timescale 1ns/1ps
// comparator_iterative
//   Multi-cycle magnitude comparator. Two WIDTH-bit operands are latched on an
//   accepted start and compared MSB-first, CHUNK bits per clock. The compare
//   stops at the first chunk that differs. An optional two's-complement mode
//   flips the sign bit of both latched operands, so the unsigned chunk walk
//   yields the signed order.
//
// Parameters
//   WIDTH     operand width; must be a multiple of CHUNK
//   CHUNK     bits compared per cycle
//   SIGNED_EN 1 = honour is_signed, 0 = always unsigned
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   compare request, sampled only while busy=0
//   A, B       in   operands, latched on accepted start
//   is_signed  in   two's-complement compare, latched on accepted start
//   busy       out  compare in progress
//   done       out  one-cycle pulse when R holds a fresh result
//   R          out  {gt, eq, lt}; held until the next compare completes
module comparator_iterative #(
    parameter int WIDTH     = 16,
    parameter int CHUNK     = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [2:0]       R
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    typedef enum logic {
        S_IDLE,
        S_COMPARE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] reg_a_q, reg_a_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;
    logic [2:0]       r_q, r_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [WIDTH-1:0] flip_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        reg_a_d   = reg_a_q;
        reg_b_d   = reg_b_q;
        r_d       = r_q;
        done_d    = 1'b0;
        chunk_a   = reg_a_q[idx_q * CHUNK +: CHUNK];
        chunk_b   = reg_b_q[idx_q * CHUNK +: CHUNK];
        // Offset-binary: inverting the sign bit of both operands maps signed
        // order onto unsigned order, so the chunk walk stays unsigned.
        flip_mask = ((SIGNED_EN != 0) && is_signed) ? MSB_MASK : '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    reg_a_d = A ^ flip_mask;
                    reg_b_d = B ^ flip_mask;
                    idx_d   = IDX_LAST;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (chunk_a > chunk_b) begin
                    r_d     = R_GT;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (chunk_a < chunk_b) begin
                    r_d     = R_LT;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (idx_q == '0) begin
                    r_d     = R_EQ;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_COMPARE);
    assign done = done_q;
    assign R    = r_q;

endmodule

// File: tb/tb_comparator_iterative.sv
`timescale 1ns/1ps
// tb_comparator_iterative
//   Randomised self-checking bench. Two DUTs share all inputs: one with signed
//   mode enabled, one built with SIGNED_EN=0. Expected results come from plain
//   signed/unsigned integer comparison; expected latency comes from the
//   position of the most significant differing bit.
module tb_comparator_iterative;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int NC = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         is_signed;
    logic         busy, done;
    logic [2:0]   R;
    logic         busy_ns, done_ns;
    logic [2:0]   R_ns;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    comparator_iterative #(.WIDTH(W), .CHUNK(C), .SIGNED_EN(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .is_signed(is_signed), .busy(busy), .done(done), .R(R)
    );

    comparator_iterative #(.WIDTH(W), .CHUNK(C), .SIGNED_EN(0)) u_dut_ns (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .is_signed(is_signed), .busy(busy_ns), .done(done_ns), .R(R_ns)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        if (sgn) begin
            if ($signed(a) > $signed(b)) return 3'b100;
            if ($signed(a) < $signed(b)) return 3'b001;
        end else begin
            if (a > b) return 3'b100;
            if (a < b) return 3'b001;
        end
        return 3'b010;
    endfunction

    // Chunks examined = chunks down to and including the one holding the
    // most significant differing bit; all of them when the operands match.
    function automatic int ref_k(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a ^ b;
        for (int p = W - 1; p >= 0; p--)
            if (d[p]) return NC - p / C;
        return NC;
    endfunction

    // Called just after a falling edge. Launches a compare, then waits for
    // done on both DUTs. Returns at the falling edge where done is seen.
    // With retrig set, start is re-pulsed and operands scrambled while busy.
    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input string tag, input bit retrig);
        logic [2:0] exp_r, exp_r_ns;
        int         exp_k, cnt;
        bit         seen;
        exp_r    = ref_r(a, b, s);
        exp_r_ns = ref_r(a, b, 1'b0);
        exp_k    = ref_k(a, b);
        A = a; B = b; is_signed = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < NC + 3; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                start = 1'b0;
                break;
            end
            cnt++;
            check({tag, "_busy"}, busy, 1'b1);
            if (retrig) begin
                A = W'($urandom); B = W'($urandom); is_signed = 1'($urandom);
                start = 1'b1;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, seen, 1'b1);
        if (seen) begin
            check({tag, "_latency"}, cnt, exp_k);
            check({tag, "_R"}, R, exp_r);
            check({tag, "_R_ns"}, R_ns, exp_r_ns);
            check({tag, "_done_ns"}, done_ns, 1'b1);
            check({tag, "_busy_lo"}, busy, 1'b0);
        end
    endtask

    task automatic after_done(input string tag, input logic [2:0] held);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_R_hold"}, R, held);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit           rs;
        logic [2:0]   held;

        rst = 1'b1; start = 1'b0; A = '0; B = '0; is_signed = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_R", R, 3'b000);
        check("rst_R_ns", R_ns, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_cmp(16'h5000, 16'h3000, 1'b0, "gt_first", 1'b0);
        after_done("gt_first", 3'b100);
        do_cmp(16'h1234, 16'h1234, 1'b0, "eq_full", 1'b0);
        after_done("eq_full", 3'b010);
        do_cmp(16'h0001, 16'h000A, 1'b0, "lt_last", 1'b0);
        after_done("lt_last", 3'b001);
        do_cmp(16'h0000, 16'h0000, 1'b0, "zero_eq", 1'b0);
        after_done("zero_eq", 3'b010);
        do_cmp(16'hFFFF, 16'h0001, 1'b1, "neg_signed", 1'b0);
        after_done("neg_signed", 3'b001);
        do_cmp(16'hFFFF, 16'h0001, 1'b0, "neg_unsigned", 1'b0);
        after_done("neg_unsigned", 3'b100);
        do_cmp(16'h8000, 16'h7FFF, 1'b1, "min_vs_max", 1'b0);
        after_done("min_vs_max", 3'b001);

        // Ignored starts while busy, then back-to-back start in the done cycle.
        do_cmp(16'h0001, 16'h000A, 1'b0, "ignore_busy", 1'b1);
        do_cmp(16'hC000, 16'hC001, 1'b1, "back2back", 1'b0);
        after_done("back2back", 3'b001);

        // Reset between the first and second compare edges.
        A = 16'h1234; B = 16'h1235; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_R", R, 3'b000);
        check("midrst_done", done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_done", done, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("postrst_done", done, 1'b0);
        do_cmp(16'h1234, 16'h1235, 1'b0, "postrst", 1'b0);
        after_done("postrst", 3'b001);

        // Random compares, biased towards long common prefixes.
        for (int n = 0; n < 80; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = W'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (W'($urandom) >> $urandom_range(0, W));
            endcase
            rs   = 1'($urandom);
            held = ref_r(ra, rb, rs);
            if ($urandom_range(0, 3) == 0) begin
                do_cmp(ra, rb, rs, "rand_b2b", 1'b0);
            end else begin
                do_cmp(ra, rb, rs, "rand", 1'b0);
                after_done("rand", held);
            end
        end
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
